// File: rtl/uart_msg_serializer_if.sv
// Message-in / byte-out bundle between the DRAM test controller, the serializer and the UART transmitter.
interface uart_msg_serializer_if #(
    parameter int DATA_WIDTH = 128
);
    logic                  i_en;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_hex;
    logic                  o_busy;
    logic [7:0]            o_byte;
    logic                  o_byte_valid;
    logic                  i_byte_ready;
    logic                  o_drop;
    logic [7:0]            o_drop_cnt;

    modport master (
        output i_en, i_data, i_hex, i_byte_ready,
        input  o_busy, o_byte, o_byte_valid, o_drop, o_drop_cnt
    );

    modport slave (
        input  i_en, i_data, i_hex, i_byte_ready,
        output o_busy, o_byte, o_byte_valid, o_drop, o_drop_cnt
    );
endinterface

// File: rtl/uart_msg_serializer.sv
// Turns one wide message per strobe into a byte stream (raw text or ASCII hex plus separator),
// with one active message, a one-deep pending slot and a saturating drop counter.
module uart_msg_serializer #(
    parameter int         DATA_WIDTH = 128,
    parameter logic [7:0] HEX_SEP    = 8'h20
) (
    input  logic                 clk,
    input  logic                 i_rstx,
    uart_msg_serializer_if.slave bus
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int NIB   = DATA_WIDTH / 4;
    localparam int IDX_W = $clog2(NIB);
    localparam logic [IDX_W-1:0] NIB_LAST  = IDX_W'(NIB - 1);
    localparam logic [IDX_W-1:0] BYTE_LAST = IDX_W'(NB - 1);

    typedef enum logic [1:0] {IDLE, SEND, SEP} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  act_hex_q, act_hex_d;
    logic [DATA_WIDTH-1:0] act_data_q, act_data_d;
    logic                  pend_vld_q, pend_vld_d;
    logic                  pend_hex_q, pend_hex_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic [7:0]            byte_q, byte_d;
    logic                  byte_vld_q, byte_vld_d;
    logic                  drop_q, drop_d;
    logic [7:0]            drop_cnt_q, drop_cnt_d;

    logic                  step, done, ld, ld_hex;
    logic [DATA_WIDTH-1:0] ld_data;

    function automatic logic [7:0] hex_digit(input logic [DATA_WIDTH-1:0] d,
                                             input logic [IDX_W-1:0] n);
        logic [3:0] v;
        v = d[{n, 2'b00} +: 4];
        return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
    endfunction

    function automatic logic [7:0] text_byte(input logic [DATA_WIDTH-1:0] d,
                                             input logic [IDX_W-1:0] n);
        return d[{n, 3'b000} +: 8];
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        act_hex_d   = act_hex_q;
        act_data_d  = act_data_q;
        pend_vld_d  = pend_vld_q;
        pend_hex_d  = pend_hex_q;
        pend_data_d = pend_data_q;
        byte_d      = byte_q;
        byte_vld_d  = byte_vld_q;
        drop_d      = 1'b0;
        drop_cnt_d  = drop_cnt_q;
        ld          = 1'b0;
        ld_hex      = bus.i_hex;
        ld_data     = bus.i_data;

        // A skipped NUL (valid low) advances unconditionally; a real byte waits for ready.
        step = (state_q == SEND) && (!byte_vld_q || bus.i_byte_ready);
        done = (step && !act_hex_q && (idx_q == BYTE_LAST)) ||
               ((state_q == SEP) && byte_vld_q && bus.i_byte_ready);

        if (state_q == IDLE) begin
            ld = bus.i_en;
        end else if (done) begin
            if (pend_vld_q) begin
                ld         = 1'b1;
                ld_data    = pend_data_q;
                ld_hex     = pend_hex_q;
                pend_vld_d = bus.i_en;
                if (bus.i_en) begin
                    pend_data_d = bus.i_data;
                    pend_hex_d  = bus.i_hex;
                end
            end else if (bus.i_en) begin
                ld = 1'b1;
            end else begin
                state_d    = IDLE;
                byte_vld_d = 1'b0;
            end
        end else begin
            if (step) begin
                if (act_hex_q) begin
                    if (idx_q == '0) begin
                        state_d    = SEP;
                        byte_d     = HEX_SEP;
                        byte_vld_d = 1'b1;
                    end else begin
                        idx_d      = idx_q - IDX_W'(1);
                        byte_d     = hex_digit(act_data_q, idx_d);
                        byte_vld_d = 1'b1;
                    end
                end else begin
                    idx_d      = idx_q + IDX_W'(1);
                    byte_d     = text_byte(act_data_q, idx_d);
                    byte_vld_d = (byte_d != 8'h00);
                end
            end
            if (bus.i_en) begin
                if (!pend_vld_q) begin
                    pend_vld_d  = 1'b1;
                    pend_data_d = bus.i_data;
                    pend_hex_d  = bus.i_hex;
                end else begin
                    drop_d = 1'b1;
                    if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
        end

        // Loading presents the first byte at the same edge, so there is no start or inter-message gap.
        if (ld) begin
            state_d    = SEND;
            act_data_d = ld_data;
            act_hex_d  = ld_hex;
            if (ld_hex) begin
                idx_d      = NIB_LAST;
                byte_d     = hex_digit(ld_data, NIB_LAST);
                byte_vld_d = 1'b1;
            end else begin
                idx_d      = '0;
                byte_d     = ld_data[7:0];
                byte_vld_d = (ld_data[7:0] != 8'h00);
            end
        end
    end

    always_ff @(posedge clk or negedge i_rstx) begin
        if (!i_rstx) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            act_hex_q  <= 1'b0;
            pend_vld_q <= 1'b0;
            byte_q     <= 8'h00;
            byte_vld_q <= 1'b0;
            drop_q     <= 1'b0;
            drop_cnt_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            act_hex_q  <= act_hex_d;
            pend_vld_q <= pend_vld_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Payload registers need no reset: they are only read while the matching slot is occupied.
    always_ff @(posedge clk) begin
        act_data_q  <= act_data_d;
        pend_data_q <= pend_data_d;
        pend_hex_q  <= pend_hex_d;
    end

    assign bus.o_busy       = (state_q != IDLE) || pend_vld_q;
    assign bus.o_byte       = byte_q;
    assign bus.o_byte_valid = byte_vld_q;
    assign bus.o_drop       = drop_q;
    assign bus.o_drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_uart_msg_serializer.sv
// Directed bench for uart_msg_serializer: text, hex, backpressure, overflow, NUL skip and reset.
module tb_uart_msg_serializer;
    logic clk;
    logic rstx;
    int   n_tests;
    int   n_fail;
    int   cyc;
    int   drop_seen;
    int   base;
    int   bc;
    logic [7:0] rx_q[$];
    int         cyc_q[$];

    uart_msg_serializer_if #(.DATA_WIDTH(128)) bus ();

    uart_msg_serializer #(.DATA_WIDTH(128), .HEX_SEP(8'h20)) dut (
        .clk    (clk),
        .i_rstx (rstx),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transfer log: records every accepted byte with the cycle it moved on.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.o_byte_valid && bus.i_byte_ready) begin
            rx_q.push_back(bus.o_byte);
            cyc_q.push_back(cyc);
        end
        if (bus.o_drop) drop_seen <= drop_seen + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rxn();
        return rx_q.size() - base;
    endfunction

    function automatic logic [7:0] rxb(input int i);
        return (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
    endfunction

    function automatic int rxc(input int i);
        return (base + i < cyc_q.size()) ? cyc_q[base + i] : -1000;
    endfunction

    task automatic send(input logic [127:0] d, input logic h);
        bus.i_data = d;
        bus.i_hex  = h;
        bus.i_en   = 1'b1;
        @(posedge clk);
        #1;
        bus.i_en   = 1'b0;
    endtask

    // Returns the number of negedges on which o_busy was seen high.
    task automatic wait_idle(input string tag, input int limit, output int busy_cyc);
        int n;
        n = 0;
        while (bus.o_busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, (n < limit), 1'b1);
        busy_cyc = n - 1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_hex_seq(input string tag);
        string hs;
        hs = "0123456789ABCDEFFEDCBA9876543210";
        chk({tag, "_cnt"}, rxn(), 33);
        for (int i = 0; i < 32; i++)
            chk($sformatf("%s_d%0d", tag, i), rxb(i), hs[i]);
        chk({tag, "_sep"}, rxb(32), 8'h20);
    endtask

    initial begin
        logic [7:0]   txt [16];
        logic [127:0] d;
        int           n;

        n_tests = 0;
        n_fail = 0;
        cyc = 0;
        drop_seen = 0;
        base = 0;
        rstx = 1'b0;
        bus.i_en = 1'b0;
        bus.i_data = '0;
        bus.i_hex = 1'b0;
        bus.i_byte_ready = 1'b1;

        #3;
        chk("rst_valid", bus.o_byte_valid, 1'b0);
        chk("rst_busy", bus.o_busy, 1'b0);
        chk("rst_byte", bus.o_byte, 8'h00);
        chk("rst_drop", bus.o_drop, 1'b0);
        chk("rst_dcnt", bus.o_drop_cnt, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rstx = 1'b1;
        @(posedge clk);
        #1;

        // Text message "WRITE:" + 8 spaces + CR LF
        txt = '{8'h57, 8'h52, 8'h49, 8'h54, 8'h45, 8'h3A, 8'h20, 8'h20,
                8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h0D, 8'h0A};
        for (int i = 0; i < 16; i++) d[8*i +: 8] = txt[i];
        base = rx_q.size();
        send(d, 1'b0);
        chk("txt_first_valid", bus.o_byte_valid, 1'b1);
        chk("txt_first_byte", bus.o_byte, 8'h57);
        wait_idle("txt_timeout", 100, bc);
        chk("txt_cnt", rxn(), 16);
        for (int i = 0; i < 16; i++) chk($sformatf("txt_b%0d", i), rxb(i), txt[i]);
        chk("txt_nogap", rxc(15) - rxc(0), 15);
        chk("txt_busy_cycles", bc, 16);

        // Hex message at full rate
        base = rx_q.size();
        send(128'h0123456789ABCDEF_FEDCBA9876543210, 1'b1);
        wait_idle("hex_timeout", 100, bc);
        chk_hex_seq("hex");
        chk("hex_nogap", rxc(32) - rxc(0), 32);

        // Backpressure while '3' is presented
        base = rx_q.size();
        send(128'h0123456789ABCDEF_FEDCBA9876543210, 1'b1);
        n = 0;
        while (!(bus.o_byte_valid && bus.o_byte == 8'h33) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bp_found", (n < 40), 1'b1);
        bus.i_byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_byte%0d", i), bus.o_byte, 8'h33);
            chk($sformatf("bp_hold_vld%0d", i), bus.o_byte_valid, 1'b1);
        end
        bus.i_byte_ready = 1'b1;
        @(posedge clk);
        #1;
        wait_idle("bp_timeout", 100, bc);
        chk_hex_seq("bp");

        // Overflow: active, pending, dropped
        base = rx_q.size();
        n = drop_seen;
        send(128'hAB, 1'b1);
        send(128'h4342, 1'b0);
        send(128'h44, 1'b0);
        chk("ovf_drop_pulse", bus.o_drop, 1'b1);
        wait_idle("ovf_timeout", 200, bc);
        chk("ovf_drop_once", drop_seen - n, 1);
        chk("ovf_drop_cnt", bus.o_drop_cnt, 8'd1);
        chk("ovf_cnt", rxn(), 35);
        chk("ovf_b0", rxb(0), 8'h30);
        chk("ovf_b30", rxb(30), 8'h41);
        chk("ovf_b31", rxb(31), 8'h42);
        chk("ovf_sep", rxb(32), 8'h20);
        chk("ovf_m2_b0", rxb(33), 8'h42);
        chk("ovf_m2_b1", rxb(34), 8'h43);
        chk("ovf_zero_gap", rxc(33) - rxc(32), 1);

        // NUL skipping
        base = rx_q.size();
        send({8'h42, 112'h0, 8'h41}, 1'b0);
        wait_idle("nul_timeout", 100, bc);
        chk("nul_cnt", rxn(), 2);
        chk("nul_b0", rxb(0), 8'h41);
        chk("nul_b1", rxb(1), 8'h42);
        chk("nul_gap", rxc(1) - rxc(0), 15);
        chk("nul_busy_cycles", bc, 16);

        base = rx_q.size();
        send(128'h0, 1'b0);
        chk("zero_valid", bus.o_byte_valid, 1'b0);
        wait_idle("zero_timeout", 100, bc);
        chk("zero_cnt", rxn(), 0);
        chk("zero_busy_cycles", bc, 16);

        // Asynchronous reset mid-message
        base = rx_q.size();
        send(128'h0123456789ABCDEF_FEDCBA9876543210, 1'b1);
        n = 0;
        while (rxn() < 4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_found", (n < 40), 1'b1);
        #2;
        rstx = 1'b0;
        #1;
        chk("rst_mid_valid", bus.o_byte_valid, 1'b0);
        chk("rst_mid_busy", bus.o_busy, 1'b0);
        chk("rst_mid_dcnt", bus.o_drop_cnt, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rstx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("rst_mid_cnt", rxn(), 4);
        chk("rst_mid_after_vld", bus.o_byte_valid, 1'b0);
        chk("rst_mid_after_busy", bus.o_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
